day05_rom_writer: RTL and testbench
===================================

DAY05_ROM_WRITER -- requirements
Module: day05_rom_writer

Interface
REQ-001 Parameter N_ADDR_BITS, default 16: log2 of internal byte-store depth (2^N_ADDR_BITS bytes).
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 rec_valid  input  1  record offered.
REQ-005 rec_ready  output  1  writer accepts record this cycle.
REQ-006 rec_kind  input  2  0=range, 1=id, 2=end, 3=reserved.
REQ-007 rec_a  input  64  range low bound, or id value.
REQ-008 rec_b  input  64  range high bound; ignored for other kinds.
REQ-009 rom_addr  input  N_ADDR_BITS+1  read byte address from consuming core.
REQ-010 rom_data  output  8  byte at rom_addr.
REQ-011 rom_valid  output  1  rom_addr < byte_count.
REQ-012 byte_count  output  N_ADDR_BITS+1  bytes written so far.
REQ-013 done  output  1  end record fully serialised; sticky until reset.
REQ-014 overflow  output  1  sticky: at least one byte dropped for lack of space.
REQ-015 proto_err  output  1  sticky: at least one record dropped as illegal.

Function
REQ-016 Record handshake: transfer when rec_valid && rec_ready; rec_ready=1 only in IDLE with done=0; rec_a/rec_b/rec_kind captured at transfer.
REQ-017 Range record SHALL emit ASCII dec(a), '-', dec(b), '\n'.
REQ-018 Id record SHALL emit dec(a), '\n'; first id record after reset SHALL first emit one extra '\n' (blank separator line) and set phase=ids.
REQ-019 End record: if phase still ranges, emit single '\n' separator; then set done=1; no further records accepted.
REQ-020 Range record with phase=ids, or rec_kind=3: accepted (one-cycle handshake), no bytes written, proto_err<=1.
REQ-021 dec(v): unsigned decimal, no leading zeros, v=0 gives "0", max 20 digits ("18446744073709551615").
REQ-022 Conversion algorithm, one step per cycle: power index p from 19 down to 0, remainder r, digit counter d; if r>=10^p then r<=r-10^p, d<=d+1; else emit '0'+d only if d!=0 or a digit already emitted or p==0, then d<=0, p<=p-1.
REQ-023 Powers of ten SHALL be a constant 64-bit table; all arithmetic 64-bit unsigned, no overflow possible.
REQ-024 States: IDLE, SEP (separator '\n'), NUM_A, DASH, NUM_B, NL, FINISH; transitions per REQ-017..019; each of SEP/DASH/NL writes exactly one byte in one cycle then advances.
REQ-025 Byte write: mem[byte_count]<=byte, byte_count<=byte_count+1, when byte_count < 2^N_ADDR_BITS.
REQ-026 Full store: byte dropped, byte_count holds at 2^N_ADDR_BITS, overflow<=1; serialisation continues normally.
REQ-027 Read port combinational: rom_data=mem[rom_addr[N_ADDR_BITS-1:0]], rom_valid=(rom_addr<byte_count); rom_addr>=2^N_ADDR_BITS always invalid.
REQ-028 Same-cycle write and read of one address: rom_data shows old contents; rom_valid for that address rises the cycle after the write.
REQ-029 rom_data SHALL be don't-care when rom_valid=0.

Reset
REQ-030 On rst: state=IDLE, phase=ranges, byte_count=0, done=0, overflow=0, proto_err=0, rec_ready=1 the following cycle; memory contents not cleared.
REQ-031 rst mid-conversion SHALL abandon the record in flight with no further writes; next accepted record writes from address 0.

Verification
REQ-032 range(3,5), id(4), end -> store "3-5\n\n4\n", byte_count=7, done=1, rom_valid=0 at rom_addr=7.
REQ-033 range(0,18446744073709551615), end -> "0-18446744073709551615\n\n", byte_count=24, proto_err=0.
REQ-034 N_ADDR_BITS=3: range(12345,67890), end -> store "12345-67", byte_count=8, overflow=1, done=1.
REQ-035 id(7), range(1,2), kind=3, end -> "\n7\n", byte_count=3, proto_err=1; rec_ready=0 after done.
REQ-036 rst asserted during NUM_A of range(99999,1) then range(1,2), end -> "1-2\n\n", byte_count=5, done=1.
REQ-037 Connect day05_core reader to read port after done with 2 ranges (3-5,10-14) and ids 1,5,8,11 -> part1_result=2, part2_result=8.

Source files
------------

// File: rtl/day05_rom_writer_if.sv
// Record handshake between a record producer and the ROM writer.
interface day05_rom_writer_if;
  logic        rec_valid;
  logic        rec_ready;
  logic [1:0]  rec_kind;
  logic [63:0] rec_a;
  logic [63:0] rec_b;

  modport master (output rec_valid, rec_kind, rec_a, rec_b, input rec_ready);
  modport slave  (input rec_valid, rec_kind, rec_a, rec_b, output rec_ready);
endinterface

// File: rtl/day05_rom_writer.sv
// Serialises range/id records as ASCII text into a byte store with a
// combinational read port for a downstream consumer.
module day05_rom_writer #(
  parameter int unsigned N_ADDR_BITS = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  day05_rom_writer_if.slave      rec,
  input  logic [N_ADDR_BITS:0]   rom_addr,
  output logic [7:0]             rom_data,
  output logic                   rom_valid,
  output logic [N_ADDR_BITS:0]   byte_count,
  output logic                   done,
  output logic                   overflow,
  output logic                   proto_err
);

  localparam int unsigned Depth = 2 ** N_ADDR_BITS;
  localparam logic [N_ADDR_BITS:0] CountOne = 1;

  localparam logic [1:0] KindRange = 2'd0;
  localparam logic [1:0] KindId    = 2'd1;
  localparam logic [1:0] KindEnd   = 2'd2;

  typedef enum logic [2:0] {
    StIdle, StSep, StNumA, StDash, StNumB, StNl, StFinish
  } state_e;

  function automatic logic [63:0] pow10(input logic [4:0] p);
    logic [63:0] v;
    case (p)
      5'd0:    v = 64'd1;
      5'd1:    v = 64'd10;
      5'd2:    v = 64'd100;
      5'd3:    v = 64'd1000;
      5'd4:    v = 64'd10000;
      5'd5:    v = 64'd100000;
      5'd6:    v = 64'd1000000;
      5'd7:    v = 64'd10000000;
      5'd8:    v = 64'd100000000;
      5'd9:    v = 64'd1000000000;
      5'd10:   v = 64'd10000000000;
      5'd11:   v = 64'd100000000000;
      5'd12:   v = 64'd1000000000000;
      5'd13:   v = 64'd10000000000000;
      5'd14:   v = 64'd100000000000000;
      5'd15:   v = 64'd1000000000000000;
      5'd16:   v = 64'd10000000000000000;
      5'd17:   v = 64'd100000000000000000;
      5'd18:   v = 64'd1000000000000000000;
      5'd19:   v = 64'd10000000000000000000;
      default: v = 64'd0;
    endcase
    return v;
  endfunction

  state_e               state_q, state_d;
  logic                 phase_ids_q, phase_ids_d;
  logic [1:0]           kind_q, kind_d;
  logic [63:0]          r_q, r_d;
  logic [63:0]          b_q, b_d;
  logic [4:0]           p_q, p_d;
  logic [3:0]           dig_q, dig_d;
  logic                 started_q, started_d;
  logic [N_ADDR_BITS:0] count_q, count_d;
  logic                 done_q, done_d;
  logic                 ovf_q, ovf_d;
  logic                 perr_q, perr_d;

  logic [7:0]  mem [Depth];
  logic [63:0] cur_pow;
  logic        ge, emit, last, transfer, full, wr_en, mem_we;
  logic [7:0]  wr_byte;

  assign cur_pow  = pow10(p_q);
  assign ge       = r_q >= cur_pow;
  // Suppress leading zeros, but the units digit is always printed so 0 gives "0".
  assign emit     = !ge && (dig_q != 4'd0 || started_q || p_q == 5'd0);
  assign last     = !ge && p_q == 5'd0;
  assign transfer = rec.rec_valid && rec.rec_ready;
  assign full     = count_q[N_ADDR_BITS];
  assign mem_we   = wr_en && !full && !rst;

  // State register and datapath flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      phase_ids_q <= 1'b0;
      kind_q      <= KindRange;
      r_q         <= '0;
      b_q         <= '0;
      p_q         <= '0;
      dig_q       <= '0;
      started_q   <= 1'b0;
      count_q     <= '0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_ids_q <= phase_ids_d;
      kind_q      <= kind_d;
      r_q         <= r_d;
      b_q         <= b_d;
      p_q         <= p_d;
      dig_q       <= dig_d;
      started_q   <= started_d;
      count_q     <= count_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      perr_q      <= perr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[count_q[N_ADDR_BITS-1:0]] <= wr_byte;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (transfer) begin
          case (rec.rec_kind)
            KindRange: state_d = phase_ids_q ? StIdle : StNumA;
            KindId:    state_d = phase_ids_q ? StNumA : StSep;
            KindEnd:   state_d = phase_ids_q ? StFinish : StSep;
            default:   state_d = StIdle;
          endcase
        end
      end
      StSep:    state_d = (kind_q == KindId) ? StNumA : StFinish;
      StNumA:   if (last) state_d = (kind_q == KindRange) ? StDash : StNl;
      StDash:   state_d = StNumB;
      StNumB:   if (last) state_d = StNl;
      StNl:     state_d = StIdle;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs of the FSM: handshake and byte to write
  always_comb begin
    rec.rec_ready = (state_q == StIdle) && !done_q;
    wr_en         = 1'b0;
    wr_byte       = 8'h00;
    unique case (state_q)
      StSep, StNl: begin
        wr_en   = 1'b1;
        wr_byte = 8'h0A;
      end
      StDash: begin
        wr_en   = 1'b1;
        wr_byte = 8'h2D;
      end
      StNumA, StNumB: begin
        wr_en   = emit;
        wr_byte = 8'h30 + {4'd0, dig_q};
      end
      default: ;
    endcase
  end

  // Datapath: record capture, digit extraction, store bookkeeping
  always_comb begin
    phase_ids_d = phase_ids_q;
    kind_d      = kind_q;
    r_d         = r_q;
    b_d         = b_q;
    p_d         = p_q;
    dig_d       = dig_q;
    started_d   = started_q;
    count_d     = count_q;
    done_d      = done_q;
    ovf_d       = ovf_q;
    perr_d      = perr_q;

    unique case (state_q)
      StIdle: begin
        if (transfer) begin
          kind_d    = rec.rec_kind;
          r_d       = rec.rec_a;
          b_d       = rec.rec_b;
          p_d       = 5'd19;
          dig_d     = 4'd0;
          started_d = 1'b0;
          case (rec.rec_kind)
            KindRange: if (phase_ids_q) perr_d = 1'b1;
            KindId:    phase_ids_d = 1'b1;
            KindEnd:   ;
            default:   perr_d = 1'b1;
          endcase
        end
      end
      StNumA, StNumB: begin
        if (ge) begin
          r_d   = r_q - cur_pow;
          dig_d = dig_q + 4'd1;
        end else begin
          if (emit) started_d = 1'b1;
          dig_d = 4'd0;
          if (p_q != 5'd0) p_d = p_q - 5'd1;
        end
      end
      StDash: begin
        r_d       = b_q;
        p_d       = 5'd19;
        dig_d     = 4'd0;
        started_d = 1'b0;
      end
      StFinish: done_d = 1'b1;
      default: ;
    endcase

    if (wr_en) begin
      if (!full) count_d = count_q + CountOne;
      else       ovf_d   = 1'b1;
    end
  end

  // Read port sees pre-write contents on a same-cycle write
  assign rom_data   = mem[rom_addr[N_ADDR_BITS-1:0]];
  assign rom_valid  = rom_addr < count_q;
  assign byte_count = count_q;
  assign done       = done_q;
  assign overflow   = ovf_q;
  assign proto_err  = perr_q;

endmodule

// File: tb/tb_day05_rom_writer.sv
// Randomised and directed checks of day05_rom_writer against a string-level text model.
module tb_day05_rom_writer;
  localparam int unsigned NAB = 6;
  localparam int DEPTH  = 1 << NAB;
  localparam int BUDGET = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  day05_rom_writer_if rec ();
  logic [NAB:0] rom_addr;
  logic [NAB:0] byte_count;
  logic [7:0]   rom_data;
  logic         rom_valid, done, overflow, proto_err;

  day05_rom_writer #(.N_ADDR_BITS(NAB)) dut (
    .clk        (clk),
    .rst        (rst),
    .rec        (rec.slave),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .rom_valid  (rom_valid),
    .byte_count (byte_count),
    .done       (done),
    .overflow   (overflow),
    .proto_err  (proto_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: expected text, truncated to the store size
  logic [7:0] exp_mem [DEPTH];
  logic [7:0] got_mem [DEPTH];
  int m_count;
  bit m_ids, m_done, m_ovf, m_perr;
  int data_bad, valid_bad;

  function automatic void model_reset();
    m_count = 0; m_ids = 0; m_done = 0; m_ovf = 0; m_perr = 0;
  endfunction

  function automatic void model_push(input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (m_count < DEPTH) begin
        exp_mem[m_count] = s[i];
        m_count++;
      end else m_ovf = 1;
    end
  endfunction

  function automatic string dec(input logic [63:0] v);
    return $sformatf("%0d", v);
  endfunction

  function automatic void model_rec(input logic [1:0] k, input logic [63:0] a,
                                    input logic [63:0] b);
    case (k)
      2'd0: if (m_ids) m_perr = 1; else model_push({dec(a), "-", dec(b), "\n"});
      2'd1: begin
        if (!m_ids) model_push("\n");
        m_ids = 1;
        model_push({dec(a), "\n"});
      end
      2'd2: begin
        if (!m_ids) model_push("\n");
        m_done = 1;
      end
      default: m_perr = 1;
    endcase
  endfunction

  function automatic logic [63:0] rand_val();
    logic [63:0] p = 64'd1;
    int k;
    case ($urandom_range(0, 4))
      0: return 64'd0;
      1: return 64'($urandom_range(0, 99));
      2: return {$urandom, $urandom};
      3: return '1;
      default: begin
        k = $urandom_range(1, 19);
        repeat (k) p = p * 64'd10;
        return p - 64'($urandom_range(0, 1));
      end
    endcase
  endfunction

  task automatic do_reset();
    rec.rec_valid = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    model_reset();
  endtask

  task automatic send_rec(input logic [1:0] k, input logic [63:0] a, input logic [63:0] b);
    int t = 0;
    @(negedge clk);
    while (rec.rec_ready !== 1'b1 && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    if (rec.rec_ready !== 1'b1) begin
      n_checks++;
      $display("FAIL send_timeout rec_ready got=%b want=1", rec.rec_ready);
    end else begin
      rec.rec_valid = 1'b1; rec.rec_kind = k; rec.rec_a = a; rec.rec_b = b;
      @(negedge clk);
      rec.rec_valid = 1'b0;
    end
  endtask

  task automatic send(input logic [1:0] k, input logic [63:0] a, input logic [63:0] b);
    send_rec(k, a, b);
    model_rec(k, a, b);
  endtask

  task automatic wait_settle();
    int t = 0;
    while (!(rec.rec_ready === 1'b1 || done === 1'b1) && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    if (!(rec.rec_ready === 1'b1 || done === 1'b1)) begin
      n_checks++;
      $display("FAIL settle_timeout ready=%b done=%b want one of them 1", rec.rec_ready, done);
    end
  endtask

  // Reads the whole store through the read port; tallies differences from the model
  task automatic dump_store();
    data_bad = 0; valid_bad = 0;
    for (int i = 0; i <= DEPTH; i++) begin
      rom_addr = (NAB + 1)'(i);
      #1;
      if (i < DEPTH) got_mem[i] = rom_data;
      if (rom_valid !== (i < m_count)) valid_bad++;
      if (i < m_count && got_mem[i] !== exp_mem[i]) data_bad++;
    end
    rom_addr = '0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if (byte_count !== m_count[NAB:0])
      $display("FAIL reset_count got=%0d want=%0d", byte_count, m_count); else n_pass++;
    n_checks++; if ({done, overflow, proto_err} !== {m_done, m_ovf, m_perr})
      $display("FAIL reset_flags got=%b want=000", {done, overflow, proto_err}); else n_pass++;
    n_checks++; if (rec.rec_ready !== 1'b1)
      $display("FAIL reset_ready got=%b want=1", rec.rec_ready); else n_pass++;
    n_checks++; if (rom_valid !== 1'b0)
      $display("FAIL reset_rom_valid got=%b want=0", rom_valid); else n_pass++;
  endtask

  task automatic test_range_id();
    do_reset();
    send(2'd0, 64'd3, 64'd5); send(2'd1, 64'd4, 64'd0); send(2'd2, 64'd0, 64'd0);
    wait_settle(); dump_store();
    n_checks++; if (byte_count !== m_count[NAB:0])
      $display("FAIL range_id_count got=%0d want=%0d", byte_count, m_count); else n_pass++;
    n_checks++; if (data_bad !== 0 || valid_bad !== 0)
      $display("FAIL range_id_store bad_bytes=%0d bad_valid=%0d want 0", data_bad, valid_bad);
    else n_pass++;
    n_checks++; if (done !== m_done)
      $display("FAIL range_id_done got=%b want=%b", done, m_done); else n_pass++;
  endtask

  task automatic test_full_range();
    do_reset();
    send(2'd0, 64'd0, '1); send(2'd2, 64'd0, 64'd0);
    wait_settle(); dump_store();
    n_checks++; if (byte_count !== m_count[NAB:0])
      $display("FAIL full_range_count got=%0d want=%0d", byte_count, m_count); else n_pass++;
    n_checks++; if (data_bad !== 0 || valid_bad !== 0)
      $display("FAIL full_range_store bad_bytes=%0d bad_valid=%0d want 0", data_bad, valid_bad);
    else n_pass++;
    n_checks++; if ({proto_err, overflow} !== {m_perr, m_ovf})
      $display("FAIL full_range_flags got=%b want=%b", {proto_err, overflow}, {m_perr, m_ovf});
    else n_pass++;
  endtask

  task automatic test_proto();
    do_reset();
    send(2'd1, 64'd7, 64'd0); send(2'd0, 64'd1, 64'd2); send(2'd3, 64'd9, 64'd9);
    send(2'd2, 64'd0, 64'd0);
    wait_settle(); dump_store();
    n_checks++; if (byte_count !== m_count[NAB:0])
      $display("FAIL proto_count got=%0d want=%0d", byte_count, m_count); else n_pass++;
    n_checks++; if (data_bad !== 0 || valid_bad !== 0)
      $display("FAIL proto_store bad_bytes=%0d bad_valid=%0d want 0", data_bad, valid_bad);
    else n_pass++;
    n_checks++; if (proto_err !== m_perr)
      $display("FAIL proto_err got=%b want=%b", proto_err, m_perr); else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++; if (rec.rec_ready !== !m_done)
      $display("FAIL proto_ready_after_done got=%b want=%b", rec.rec_ready, !m_done);
    else n_pass++;
  endtask

  task automatic test_overflow();
    do_reset();
    send(2'd0, '1, '1); send(2'd1, '1, 64'd0); send(2'd1, 64'd123, 64'd0);
    send(2'd2, 64'd0, 64'd0);
    wait_settle(); dump_store();
    n_checks++; if (byte_count !== m_count[NAB:0])
      $display("FAIL overflow_count got=%0d want=%0d", byte_count, m_count); else n_pass++;
    n_checks++; if (data_bad !== 0 || valid_bad !== 0)
      $display("FAIL overflow_store bad_bytes=%0d bad_valid=%0d want 0", data_bad, valid_bad);
    else n_pass++;
    n_checks++; if ({overflow, done} !== {m_ovf, m_done})
      $display("FAIL overflow_flags got=%b want=%b", {overflow, done}, {m_ovf, m_done});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_rec(2'd0, 64'd99999, 64'd1);
    repeat (5) @(negedge clk);
    do_reset();
    send(2'd0, 64'd1, 64'd2); send(2'd2, 64'd0, 64'd0);
    wait_settle(); dump_store();
    n_checks++; if (byte_count !== m_count[NAB:0])
      $display("FAIL reset_mid_count got=%0d want=%0d", byte_count, m_count); else n_pass++;
    n_checks++; if (data_bad !== 0 || valid_bad !== 0)
      $display("FAIL reset_mid_store bad_bytes=%0d bad_valid=%0d want 0", data_bad, valid_bad);
    else n_pass++;
    n_checks++; if (done !== m_done)
      $display("FAIL reset_mid_done got=%b want=%b", done, m_done); else n_pass++;
  endtask

  task automatic test_random();
    int nrec, sel;
    logic [1:0] k;
    for (int it = 0; it < 12; it++) begin
      do_reset();
      nrec = $urandom_range(1, 6);
      for (int j = 0; j < nrec; j++) begin
        sel = $urandom_range(0, 9);
        k = (sel < 4) ? 2'd0 : (sel < 8) ? 2'd1 : 2'd3;
        send(k, rand_val(), rand_val());
      end
      send(2'd2, 64'd0, 64'd0);
      wait_settle(); dump_store();
      n_checks++; if (byte_count !== m_count[NAB:0])
        $display("FAIL random%0d_count got=%0d want=%0d", it, byte_count, m_count);
      else n_pass++;
      n_checks++; if (data_bad !== 0 || valid_bad !== 0)
        $display("FAIL random%0d_store bad_bytes=%0d bad_valid=%0d want 0",
                 it, data_bad, valid_bad);
      else n_pass++;
      n_checks++; if ({done, overflow, proto_err} !== {m_done, m_ovf, m_perr})
        $display("FAIL random%0d_flags got=%b want=%b", it, {done, overflow, proto_err},
                 {m_done, m_ovf, m_perr});
      else n_pass++;
    end
  endtask

  initial begin
    rec.rec_valid = 1'b0;
    rec.rec_kind  = 2'd0;
    rec.rec_a     = '0;
    rec.rec_b     = '0;
    rom_addr      = '0;
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_range_id();
    test_full_range();
    test_proto();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
